// File: rtl/serial_magnitude_comparator.sv
// Bit-serial, MSB-first unsigned magnitude comparator with start/busy/done handshake.
// Stops at the first differing bit; results are held until the next compare finishes.
module serial_magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             output_greater_than,
    output logic             output_equal
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] x_sr, y_sr, x_sr_nxt, y_sr_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             busy_nxt, done_nxt, gt_nxt, eq_nxt;
    logic             bits_differ, last_bit;

    assign bits_differ = x_sr[WIDTH-1] ^ y_sr[WIDTH-1];
    assign last_bit    = (idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            x_sr                <= '0;
            y_sr                <= '0;
            idx                 <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            output_greater_than <= 1'b0;
            output_equal        <= 1'b0;
        end else begin
            state               <= state_nxt;
            x_sr                <= x_sr_nxt;
            y_sr                <= y_sr_nxt;
            idx                 <= idx_nxt;
            busy                <= busy_nxt;
            done                <= done_nxt;
            output_greater_than <= gt_nxt;
            output_equal        <= eq_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COMPARE;
            S_COMPARE: if (bits_differ || last_bit) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        x_sr_nxt = x_sr;
        y_sr_nxt = y_sr;
        idx_nxt  = idx;
        gt_nxt   = output_greater_than;
        eq_nxt   = output_equal;
        busy_nxt = (state_nxt == S_COMPARE);
        done_nxt = (state_nxt == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    x_sr_nxt = x;
                    y_sr_nxt = y;
                    idx_nxt  = IDX_W'(WIDTH - 1);
                end
            end
            S_COMPARE: begin
                x_sr_nxt = {x_sr[WIDTH-2:0], 1'b0};
                y_sr_nxt = {y_sr[WIDTH-2:0], 1'b0};
                if (bits_differ) begin
                    gt_nxt = x_sr[WIDTH-1];
                    eq_nxt = 1'b0;
                end else if (last_bit) begin
                    gt_nxt = 1'b0;
                    eq_nxt = 1'b1;
                end else begin
                    idx_nxt = idx - IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomized checks of serial_magnitude_comparator against a
// plain-arithmetic model of result and first-difference latency.
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] x, y;
    logic             busy, done, gt, eq;

    int checks   = 0;
    int failures = 0;

    logic exp_gt, exp_eq;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .x                   (x),
        .y                   (y),
        .busy                (busy),
        .done                (done),
        .output_greater_than (gt),
        .output_equal        (eq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles from the start edge to the done edge: position of the first differing bit from the MSB.
    function automatic int model_latency(input int xv, input int yv);
        int p;
        int d;
        p = -1;
        d = xv ^ yv;
        for (int b = 0; b < WIDTH; b++)
            if (((d >> b) & 1) == 1) p = b;
        return (p < 0) ? WIDTH : WIDTH - p;
    endfunction

    task automatic run_compare(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        int  lat;
        bit  got;
        exp_gt = (xv > yv);
        exp_eq = (xv == yv);
        @(negedge clk);
        x = xv; y = yv; start = 1'b1;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        chk("done_after_start", 32'(done), 0);
        start = 1'($urandom_range(0, 1));
        x = WIDTH'($urandom_range(0, 15));
        y = WIDTH'($urandom_range(0, 15));
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= WIDTH + 1; c++) begin
            if (!got) begin
                @(negedge clk);
                lat = c;
                if (done) got = 1'b1;
                else begin
                    chk("busy_mid", 32'(busy), 1);
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
        chk("done_seen", 32'(got), 1);
        chk("latency", 32'(lat), 32'(model_latency(int'(xv), int'(yv))));
        chk("gt", 32'(gt), 32'(exp_gt));
        chk("eq", 32'(eq), 32'(exp_eq));
        chk("busy_in_done", 32'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_end", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        @(negedge clk);
        chk("start_in_done_ignored", 32'(busy), 0);
        chk("gt_hold", 32'(gt), 32'(exp_gt));
        chk("eq_hold", 32'(eq), 32'(exp_eq));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_gt", 32'(gt), 0);
        chk("rst_eq", 32'(eq), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_done", 32'(done), 0);
        chk("post_rst_gt", 32'(gt), 0);
        chk("post_rst_eq", 32'(eq), 0);

        run_compare(4'd5, 4'd4);
        run_compare(4'd6, 4'd9);
        run_compare(4'd3, 4'd3);
        run_compare(4'd0, 4'd0);
        run_compare(4'd15, 4'd0);
        run_compare(4'd0, 4'd15);

        // Start held high, x changed after capture, then re-trigger from IDLE.
        @(negedge clk);
        x = 4'd12; y = 4'd8; start = 1'b1;
        @(negedge clk);
        chk("held_busy_e0", 32'(busy), 1);
        @(negedge clk);
        chk("held_busy_e1", 32'(busy), 1);
        chk("held_done_e1", 32'(done), 0);
        x = 4'd0;
        @(negedge clk);
        chk("held_done_k2", 32'(done), 1);
        chk("held_gt_k2", 32'(gt), 1);
        chk("held_eq_k2", 32'(eq), 0);
        @(negedge clk);
        chk("held_idle_done", 32'(done), 0);
        chk("held_idle_busy", 32'(busy), 0);
        @(negedge clk);
        chk("held_retrigger_busy", 32'(busy), 1);
        chk("held_retrigger_done", 32'(done), 0);
        @(negedge clk);
        chk("held_second_done", 32'(done), 1);
        chk("held_second_gt", 32'(gt), 0);
        chk("held_second_eq", 32'(eq), 0);
        start = 1'b0;
        @(negedge clk);
        chk("held_second_pulse_end", 32'(done), 0);

        run_compare(4'd9, 4'd9);

        // Reset in the middle of a compare.
        @(negedge clk);
        x = 4'd2; y = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_gt", 32'(gt), 0);
        chk("abort_eq", 32'(eq), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < WIDTH + 2; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end
        run_compare(4'd2, 4'd3);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_compare(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
